dtl_alu_pipe: RTL and testbench
===============================

Name: dtl_alu_pipe

Overview:
Parametrised successor to the single-register task-based action unit. It is a 2-stage pipelined ALU with a valid/ready handshake on both sides, an 8-entry opcode set, optional saturation, an optional post-adjust stage, an accumulate mode that feeds the last result back as operand A, and a result counter. It sits between the operand sequencer and the result collector in the datapath.

Parameters:
- WIDTH, 8: operand and result width in bits (legal range 4 to 64).
- SATURATE, 0: 1 clamps ADD overflow to all-ones and SUB underflow to zero; 0 wraps mod 2^WIDTH.
- ADJ_EN, 1: 1 enables the post-adjust stage; 0 makes the adjust stage pass temp through unchanged.
- CNT_W, 16: width of the result counter.

Ports:
- dtl_clk, in, 1: clock, rising edge.
- dtl_rst_n, in, 1: reset, asynchronous, active-low.
- dtl_in_valid, in, 1: input operation valid.
- dtl_in_ready, out, 1: input can be accepted.
- dtl_in_a, in, WIDTH: operand A.
- dtl_in_b, in, WIDTH: operand B.
- dtl_in_op, in, 3: opcode.
- dtl_in_acc, in, 1: replace operand A with dtl_acc_value.
- dtl_out_valid, out, 1: result valid.
- dtl_out_ready, in, 1: downstream accepts the result.
- dtl_out_data, out, WIDTH: result.
- dtl_acc_value, out, WIDTH: accumulator, which holds the last result loaded into stage 2.
- dtl_res_count, out, CNT_W: number of completed output handshakes.

Behaviour:
- Reset is asynchronous and active-low on dtl_rst_n, with dtl_clk as the clock. On reset, s1_valid, dtl_out_valid, dtl_out_data, dtl_acc_value and dtl_res_count all go to 0. A reset mid-operation discards everything in flight, and no partial result is emitted.
- Opcodes (stage 1, temp = f(A, B), where A = dtl_acc_value if dtl_in_acc else dtl_in_a):
  - 000: OR
  - 001: SUB (A-B)
  - 010: AND
  - 011: ADD
  - 100: XOR
  - 101: A<<1, with the MSB dropped
  - 110: pass A
  - 111: pass B
- Saturation: with SATURATE=1, ADD with a carry-out gives all-ones, and SUB with A<B gives 0. No other opcode is affected.
- Post-adjust (stage 2, when ADJ_EN=1), selected by temp[1:0]:
  - 00: ~temp
  - 01: temp+1
  - 10: temp-1
  - 11: temp
  - The +1 and -1 wrap mod 2^WIDTH and are never saturated.
- Stage 1 register (s1_valid, s1_temp) loads on an input handshake (dtl_in_valid && dtl_in_ready).
  - If stage 1 is not reloaded, s1_valid clears when stage 1 moves to stage 2.
- Stage 2 / output register advances when s2_adv = s1_valid && (!dtl_out_valid || dtl_out_ready).
  - On s2_adv: dtl_out_data <= adjust(s1_temp), dtl_out_valid <= 1, and dtl_acc_value <= the same value.
  - On an output handshake without s2_adv, dtl_out_valid clears.
  - dtl_out_data holds stable while dtl_out_valid && !dtl_out_ready.
- Ready logic: dtl_in_ready = (!s1_valid || s2_adv) && !(dtl_in_acc && s1_valid).
  - This is the accumulate interlock: an acc request waits until no older op sits in stage 1. This guarantees dtl_acc_value holds the immediately preceding result.
  - dtl_in_ready depends combinationally on dtl_in_acc. Upstream must hold dtl_in_acc stable while dtl_in_valid is high.
- Latency: an op accepted at edge N shows dtl_out_valid after edge N+1. Throughput is 1 op per cycle with dtl_out_ready=1, and 1 op per 2 cycles for back-to-back acc ops.
- Stall: with dtl_out_ready=0 and both stages full, dtl_in_ready=0. No op is dropped or duplicated.
- Counter: dtl_res_count increments on each output handshake and wraps from all-ones to 0.
- A simultaneous input and output handshake in the same cycle is legal: both stages advance together.
- Arithmetic is unsigned. Internal carry uses WIDTH+1 bits.

Test Plan:
1. Default parameters, dtl_out_ready=1, sequence of ops -> outputs in order, each 2 cycles after acceptance:
   - ADD a=0x10, b=0x05 -> 0x16
   - OR a=0x0C, b=0x03 -> 0x0F
   - AND a=0xF0, b=0x3C -> 0xCF
   - SUB a=0x03, b=0x05 -> 0xFD
   - dtl_res_count = 4 afterwards.
2. SATURATE=1: SUB a=0x03, b=0x05 -> 0xFF; ADD a=0xF0, b=0x20 -> temp 0xFF -> 0xFF. With SATURATE=0 the same ADD gives temp 0x10 -> 0xEF.
3. Accumulate chain: ADD a=0x10, b=0x05 (result 0x16), then back-to-back acc ADD b=0x01 -> dtl_in_ready=0 for one cycle, then the result is 0x17 and dtl_acc_value=0x17.
4. Backpressure: hold dtl_out_ready=0 for 5 cycles while feeding 4 valid ops -> exactly 2 are accepted, dtl_out_data stays stable, and all results drain in order once ready is released.
5. ADJ_EN=0, WIDTH=16: XOR a=0x1234, b=0x00FF -> 0x12CB. Shift a=0x8001 -> 0x0002.
6. Assert dtl_rst_n low asynchronously with both stages full -> outputs are 0 immediately. The first op after release is accepted and the count restarts at 1.

Source files
------------

// File: rtl/dtl_alu_pipe.sv
// dtl_alu_pipe: two-stage pipelined ALU with valid/ready handshakes, optional saturation and post-adjust, accumulate feedback and a result counter
module dtl_alu_pipe #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int ADJ_EN   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             dtl_clk,
    input  logic             dtl_rst_n,
    input  logic             dtl_in_valid,
    output logic             dtl_in_ready,
    input  logic [WIDTH-1:0] dtl_in_a,
    input  logic [WIDTH-1:0] dtl_in_b,
    input  logic [2:0]       dtl_in_op,
    input  logic             dtl_in_acc,
    output logic             dtl_out_valid,
    input  logic             dtl_out_ready,
    output logic [WIDTH-1:0] dtl_out_data,
    output logic [WIDTH-1:0] dtl_acc_value,
    output logic [CNT_W-1:0] dtl_res_count
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_temp;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] temp;
    logic [WIDTH-1:0] adj;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             s2_adv;
    logic             in_hs;
    logic             out_hs;

    assign op_a   = dtl_in_acc ? dtl_acc_value : dtl_in_a;
    assign sum    = {1'b0, op_a} + {1'b0, dtl_in_b};
    assign diff   = {1'b0, op_a} - {1'b0, dtl_in_b};
    assign s2_adv = s1_valid && (!dtl_out_valid || dtl_out_ready);
    assign out_hs = dtl_out_valid && dtl_out_ready;
    assign in_hs  = dtl_in_valid && dtl_in_ready;
    assign dtl_in_ready = (!s1_valid || s2_adv) && !(dtl_in_acc && s1_valid);

    always_comb begin
        temp = '0;
        case (dtl_in_op)
            3'b000:  temp = op_a | dtl_in_b;
            3'b001:  temp = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            3'b010:  temp = op_a & dtl_in_b;
            3'b011:  temp = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            3'b100:  temp = op_a ^ dtl_in_b;
            3'b101:  temp = {op_a[WIDTH-2:0], 1'b0};
            3'b110:  temp = op_a;
            default: temp = dtl_in_b;
        endcase
    end

    always_comb begin
        adj = (ADJ_EN == 0)          ? s1_temp :
              (s1_temp[1:0] == 2'b00) ? ~s1_temp :
              (s1_temp[1:0] == 2'b01) ? s1_temp + WIDTH'(1) :
              (s1_temp[1:0] == 2'b10) ? s1_temp - WIDTH'(1) : s1_temp;
    end

    always_ff @(posedge dtl_clk or negedge dtl_rst_n) begin
        if (!dtl_rst_n) begin
            s1_valid      <= 1'b0;
            s1_temp       <= '0;
            dtl_out_valid <= 1'b0;
            dtl_out_data  <= '0;
            dtl_acc_value <= '0;
            dtl_res_count <= '0;
        end else begin
            if (in_hs) begin
                s1_valid <= 1'b1;
                s1_temp  <= temp;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
            if (s2_adv) begin
                dtl_out_valid <= 1'b1;
                dtl_out_data  <= adj;
                dtl_acc_value <= adj;
            end else if (out_hs) begin
                dtl_out_valid <= 1'b0;
            end
            if (out_hs)
                dtl_res_count <= dtl_res_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dtl_alu_pipe.sv
// tb_dtl_alu_pipe: scoreboard bench for dtl_alu_pipe across default, saturating and 16-bit no-adjust builds
module tb_dtl_alu_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic        acc = 1'b0, ordy = 1'b1;
    logic        v_d = 1'b0, v_s = 1'b0, v_w = 1'b0;
    logic        rdy_d, rdy_s, rdy_w, ov_d, ov_s, ov_w;
    logic [7:0]  data_d, data_s, accv_d, accv_s;
    logic [15:0] data_w, accv_w, cnt_d, cnt_s, cnt_w;

    int compared = 0;
    int mismatched = 0;
    int unsigned q_d[$], q_s[$], q_w[$];
    int unsigned accm[3] = '{0, 0, 0};
    int unsigned e_d, e_s, e_w;

    always #5 clk = ~clk;

    dtl_alu_pipe u_d (
        .dtl_clk(clk), .dtl_rst_n(rst_n), .dtl_in_valid(v_d), .dtl_in_ready(rdy_d),
        .dtl_in_a(a[7:0]), .dtl_in_b(b[7:0]), .dtl_in_op(op), .dtl_in_acc(acc),
        .dtl_out_valid(ov_d), .dtl_out_ready(ordy), .dtl_out_data(data_d),
        .dtl_acc_value(accv_d), .dtl_res_count(cnt_d)
    );

    dtl_alu_pipe #(.SATURATE(1)) u_s (
        .dtl_clk(clk), .dtl_rst_n(rst_n), .dtl_in_valid(v_s), .dtl_in_ready(rdy_s),
        .dtl_in_a(a[7:0]), .dtl_in_b(b[7:0]), .dtl_in_op(op), .dtl_in_acc(acc),
        .dtl_out_valid(ov_s), .dtl_out_ready(ordy), .dtl_out_data(data_s),
        .dtl_acc_value(accv_s), .dtl_res_count(cnt_s)
    );

    dtl_alu_pipe #(.WIDTH(16), .ADJ_EN(0)) u_w (
        .dtl_clk(clk), .dtl_rst_n(rst_n), .dtl_in_valid(v_w), .dtl_in_ready(rdy_w),
        .dtl_in_a(a), .dtl_in_b(b), .dtl_in_op(op), .dtl_in_acc(acc),
        .dtl_out_valid(ov_w), .dtl_out_ready(ordy), .dtl_out_data(data_w),
        .dtl_acc_value(accv_w), .dtl_res_count(cnt_w)
    );

    function automatic int unsigned model(input int o, input int unsigned x, input int unsigned y,
                                          input bit sat, input bit adj_en, input int w);
        int unsigned m, t;
        m = (32'd1 << w) - 1;
        case (o)
            0: t = x | y;
            1: t = (sat && x < y) ? 0 : (x - y) & m;
            2: t = x & y;
            3: t = (sat && x + y > m) ? m : (x + y) & m;
            4: t = x ^ y;
            5: t = (x << 1) & m;
            6: t = x;
            default: t = y;
        endcase
        if (!adj_en) return t;
        case (t & 3)
            0: return ~t & m;
            1: return (t + 1) & m;
            2: return (t - 1) & m;
            default: return t;
        endcase
    endfunction

    task automatic accept(input int sel, input int o, input int unsigned ia, input int unsigned ib, input bit iacc);
        int unsigned e;
        e = model(o, iacc ? accm[sel] : ia, ib, sel == 1, sel != 2, sel == 2 ? 16 : 8);
        accm[sel] = e;
        if (sel == 0) q_d.push_back(e);
        else if (sel == 1) q_s.push_back(e);
        else q_w.push_back(e);
    endtask

    task automatic drive(input int sel, input int o, input int unsigned ia, input int unsigned ib,
                         input bit iacc, output int stalls);
        bit done, r;
        stalls = 0;
        done = 0;
        op = 3'(o);
        a = 16'(ia);
        b = 16'(ib);
        acc = iacc;
        {v_w, v_s, v_d} = 3'(1 << sel);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            r = sel == 0 ? rdy_d : sel == 1 ? rdy_s : rdy_w;
            if (r) begin
                accept(sel, o, ia, ib, iacc);
                done = 1;
            end else stalls++;
            @(posedge clk); #1;
        end
        {v_w, v_s, v_d} = '0;
        acc = 1'b0;
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL drive_timeout sel=%0d op=%0d never accepted", sel, o);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = q_d.size() == 0 && q_s.size() == 0 && q_w.size() == 0 && !ov_d && !ov_s && !ov_w;
        end
        @(posedge clk); #1;
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout pending d=%0d s=%0d w=%0d", q_d.size(), q_s.size(), q_w.size());
        end
    endtask

    always @(negedge clk) if (rst_n && ov_d && ordy) begin
        compared++;
        if (q_d.size() == 0) begin
            mismatched++;
            $display("FAIL sb_d unexpected output got=%h expected none", data_d);
        end else begin
            e_d = q_d.pop_front();
            if (32'(data_d) !== e_d) begin
                mismatched++;
                $display("FAIL sb_d got=%h exp=%h", data_d, e_d);
            end
        end
    end

    always @(negedge clk) if (rst_n && ov_s && ordy) begin
        compared++;
        if (q_s.size() == 0) begin
            mismatched++;
            $display("FAIL sb_s unexpected output got=%h expected none", data_s);
        end else begin
            e_s = q_s.pop_front();
            if (32'(data_s) !== e_s) begin
                mismatched++;
                $display("FAIL sb_s got=%h exp=%h", data_s, e_s);
            end
        end
    end

    always @(negedge clk) if (rst_n && ov_w && ordy) begin
        compared++;
        if (q_w.size() == 0) begin
            mismatched++;
            $display("FAIL sb_w unexpected output got=%h expected none", data_w);
        end else begin
            e_w = q_w.pop_front();
            if (32'(data_w) !== e_w) begin
                mismatched++;
                $display("FAIL sb_w got=%h exp=%h", data_w, e_w);
            end
        end
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++; if (ov_d !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got=%b exp=0", ov_d); end
        compared++; if (data_d !== 8'h00) begin mismatched++; $display("FAIL reset_out_data got=%h exp=00", data_d); end
        compared++; if (accv_d !== 8'h00) begin mismatched++; $display("FAIL reset_acc got=%h exp=00", accv_d); end
        compared++; if (cnt_d !== 16'h0) begin mismatched++; $display("FAIL reset_count got=%0d exp=0", cnt_d); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared++; if (rdy_d !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready got=%b exp=1", rdy_d); end
    endtask

    task automatic test_ops();
        int st;
        drive(0, 3, 'h10, 'h05, 0, st);
        drive(0, 0, 'h0C, 'h03, 0, st);
        drive(0, 2, 'hF0, 'h3C, 0, st);
        drive(0, 1, 'h03, 'h05, 0, st);
        drain();
        compared++; if (cnt_d !== 16'd4) begin mismatched++; $display("FAIL ops_count got=%0d exp=4", cnt_d); end
        compared++; if (accv_d !== 8'hFD) begin mismatched++; $display("FAIL ops_acc got=%h exp=fd", accv_d); end
    endtask

    task automatic test_latency();
        int st;
        drive(0, 3, 'h01, 'h01, 0, st);
        @(negedge clk);
        compared++; if (ov_d !== 1'b0) begin mismatched++; $display("FAIL latency_early got=%b exp=0", ov_d); end
        @(negedge clk);
        compared++; if (ov_d !== 1'b1) begin mismatched++; $display("FAIL latency_valid got=%b exp=1", ov_d); end
        compared++; if (data_d !== 8'h01) begin mismatched++; $display("FAIL latency_data got=%h exp=01", data_d); end
        drain();
    endtask

    task automatic test_saturate();
        int st;
        drive(1, 1, 'h03, 'h05, 0, st);
        drive(1, 3, 'hF0, 'h20, 0, st);
        drive(0, 3, 'hF0, 'h20, 0, st);
        drain();
        compared++; if (accv_s !== 8'hFF) begin mismatched++; $display("FAIL sat_add got=%h exp=ff", accv_s); end
        compared++; if (accv_d !== 8'hEF) begin mismatched++; $display("FAIL wrap_add got=%h exp=ef", accv_d); end
        compared++; if (cnt_s !== 16'd2) begin mismatched++; $display("FAIL sat_count got=%0d exp=2", cnt_s); end
    endtask

    task automatic test_acc();
        int st0, st1;
        drive(0, 3, 'h10, 'h05, 0, st0);
        drive(0, 3, 'h00, 'h01, 1, st1);
        compared++; if (st0 != 0) begin mismatched++; $display("FAIL acc_first_stall got=%0d exp=0", st0); end
        compared++; if (st1 != 1) begin mismatched++; $display("FAIL acc_interlock_stall got=%0d exp=1", st1); end
        drain();
        compared++; if (accv_d !== 8'h17) begin mismatched++; $display("FAIL acc_value got=%h exp=17", accv_d); end
    endtask

    task automatic test_backpressure();
        int bo[4] = '{4, 0, 3, 2};
        int unsigned ba[4] = '{'h0F, 'h01, 'h04, 'hFF};
        int unsigned bb[4] = '{'hF0, 'h02, 'h04, 'h5D};
        int i;
        bit have, acc_now;
        logic [7:0] held;
        i = 0;
        have = 0;
        held = '0;
        ordy = 1'b0;
        for (int c = 0; c < 25 && i < 4; c++) begin
            if (c == 5) begin
                compared++; if (i != 2) begin mismatched++; $display("FAIL bp_accepted got=%0d exp=2", i); end
                ordy = 1'b1;
            end
            op = 3'(bo[i]);
            a = 16'(ba[i]);
            b = 16'(bb[i]);
            v_d = 1'b1;
            @(negedge clk);
            if (!ordy && ov_d) begin
                if (have) begin
                    compared++;
                    if (data_d !== held) begin mismatched++; $display("FAIL bp_stable got=%h exp=%h", data_d, held); end
                end
                held = data_d;
                have = 1;
            end
            acc_now = rdy_d;
            if (acc_now) accept(0, bo[i], ba[i], bb[i], 0);
            @(posedge clk); #1;
            if (acc_now) i++;
        end
        v_d = 1'b0;
        ordy = 1'b1;
        compared++; if (i != 4) begin mismatched++; $display("FAIL bp_all_accepted got=%0d exp=4", i); end
        drain();
    endtask

    task automatic test_wide();
        int st;
        drive(2, 4, 'h1234, 'h00FF, 0, st);
        drive(2, 5, 'h8001, 'h0000, 0, st);
        drain();
        compared++; if (accv_w !== 16'h0002) begin mismatched++; $display("FAIL wide_shift got=%h exp=0002", accv_w); end
        compared++; if (cnt_w !== 16'd2) begin mismatched++; $display("FAIL wide_count got=%0d exp=2", cnt_w); end
    endtask

    task automatic test_async_reset();
        int st;
        ordy = 1'b0;
        drive(0, 3, 'h10, 'h05, 0, st);
        drive(0, 0, 'h0C, 'h03, 0, st);
        compared++; if (ov_d !== 1'b1 || rdy_d !== 1'b0) begin
            mismatched++; $display("FAIL full_stall valid=%b ready=%b exp valid=1 ready=0", ov_d, rdy_d);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (ov_d !== 1'b0) begin mismatched++; $display("FAIL areset_valid got=%b exp=0", ov_d); end
        compared++; if (data_d !== 8'h00) begin mismatched++; $display("FAIL areset_data got=%h exp=00", data_d); end
        compared++; if (accv_d !== 8'h00) begin mismatched++; $display("FAIL areset_acc got=%h exp=00", accv_d); end
        compared++; if (cnt_d !== 16'h0) begin mismatched++; $display("FAIL areset_count got=%0d exp=0", cnt_d); end
        q_d.delete(); q_s.delete(); q_w.delete();
        accm = '{0, 0, 0};
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy = 1'b1;
        drive(0, 0, 'h0C, 'h03, 0, st);
        compared++; if (st != 0) begin mismatched++; $display("FAIL post_reset_accept stalls=%0d exp=0", st); end
        drain();
        compared++; if (cnt_d !== 16'd1) begin mismatched++; $display("FAIL post_reset_count got=%0d exp=1", cnt_d); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_latency();
        test_saturate();
        test_acc();
        test_backpressure();
        test_wide();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
